// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scan controller for an 8-digit 7-segment stage.
// Holds one hex nibble per digit, steps the digit select at a programmable rate,
// and presents num/sel/blank (with optional leading-zero suppression) downstream.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic       lz_en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       digit_tick
);

  localparam int                CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]        SEL_LAST = 3'(NUM_DIGITS - 1);

  // Storage is always 8 entries wide; slots at or above NUM_DIGITS are never
  // written and stay zero, which keeps indexing by the 3-bit sel in range.
  logic [7:0][3:0]  digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             tick_q, tick_d;
  logic             wr_valid;
  logic             higher_zero;

  assign wr_valid = ({1'b0, wr_addr} < 4'(NUM_DIGITS));

  // Next-state: prescaler, digit select advance, tick pulse and register writes.
  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    digit_d = digit_q;
    if (scan_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        sel_d  = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (wr_en && wr_valid) begin
      digit_d[wr_addr] = wr_data;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      tick_q  <= tick_d;
    end
  end

  // Leading-zero test: every digit above the current one must be zero.
  always_comb begin
    higher_zero = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      if ((k > 32'(sel_q)) && (digit_q[3'(k)] != 4'h0)) begin
        higher_zero = 1'b0;
      end
    end
  end

  assign num        = digit_q[sel_q];
  assign sel        = sel_q;
  assign digit_tick = tick_q;
  assign blank      = lz_en && (sel_q != 3'd0) && (digit_q[sel_q] == 4'h0) && higher_zero;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: an 8-digit and a 4-digit instance share
// stimulus and are compared against a slot-count reference model every cycle.
module tb_seg_scan_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en, lz_en, wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;

  logic [3:0] num8, num4;
  logic [2:0] sel8, sel4;
  logic       blank8, blank4, tick8, tick4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: number of enabled cycles since reset, plus digit contents.
  int en_cycles;
  int m_tick;
  int d8[8];
  int d4[8];

  seg_scan_driver #(.REFRESH_DIV(DIV), .NUM_DIGITS(8)) dut8 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .lz_en(lz_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .num(num8), .sel(sel8), .blank(blank8),
    .digit_tick(tick8)
  );

  seg_scan_driver #(.REFRESH_DIV(DIV), .NUM_DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .scan_en(scan_en), .lz_en(lz_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .num(num4), .sel(sel4), .blank(blank4),
    .digit_tick(tick4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_sel(input int n);
    return (en_cycles / DIV) % n;
  endfunction

  function automatic int exp_blank8();
    int s = exp_sel(8);
    if (!lz_en || s == 0) return 0;
    for (int k = s; k < 8; k++) if (d8[k] != 0) return 0;
    return 1;
  endfunction

  function automatic int exp_blank4();
    int s = exp_sel(4);
    if (!lz_en || s == 0) return 0;
    for (int k = s; k < 4; k++) if (d4[k] != 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    en_cycles = 0;
    m_tick    = 0;
    for (int k = 0; k < 8; k++) begin
      d8[k] = 0;
      d4[k] = 0;
    end
  endtask

  task automatic check_all();
    check("sel8",   int'(sel8),   exp_sel(8));
    check("num8",   int'(num8),   d8[exp_sel(8)]);
    check("blank8", int'(blank8), exp_blank8());
    check("tick8",  int'(tick8),  m_tick);
    check("sel4",   int'(sel4),   exp_sel(4));
    check("num4",   int'(num4),   d4[exp_sel(4)]);
    check("blank4", int'(blank4), exp_blank4());
    check("tick4",  int'(tick4),  m_tick);
  endtask

  // One clock: apply model for the edge using the held inputs, then check after settling.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (scan_en) begin
        en_cycles++;
        m_tick = (en_cycles % DIV == 0) ? 1 : 0;
      end else begin
        m_tick = 0;
      end
      if (wr_en) begin
        d8[wr_addr] = int'(wr_data);
        if (wr_addr < 3'd4) d4[wr_addr] = int'(wr_data);
      end
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_digit(input int a, input int v);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = 4'(v);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pat[8];
    rst = 1'b1; scan_en = 1'b0; lz_en = 1'b0; wr_en = 1'b0;
    wr_addr = 3'd0; wr_data = 4'd0;
    model_reset();

    // Reset state
    do_reset();
    check("rst_sel", int'(sel8), 0);
    check("rst_num", int'(num8), 0);
    check("rst_blank", int'(blank8), 0);
    check("rst_tick", int'(tick8), 0);

    // Free-running scan through two full rotations
    scan_en = 1'b1;
    run(8 * DIV * 2 + 3);

    // Digits 0..7 = 8..1 then watch num follow sel
    scan_en = 1'b0;
    for (int k = 0; k < 8; k++) write_digit(k, 8 - k);
    scan_en = 1'b1;
    run(8 * DIV + 2);

    // Leading-zero pattern d0=9, d2=3
    scan_en = 1'b0;
    pat = '{9, 0, 3, 0, 0, 0, 0, 0};
    for (int k = 0; k < 8; k++) write_digit(k, pat[k]);
    scan_en = 1'b1;
    lz_en   = 1'b1;
    run(8 * DIV + 1);
    lz_en   = 1'b0;
    run(8 * DIV);

    // Freeze at sel 3, count 2, then resume
    do_reset();
    scan_en = 1'b1;
    run(3 * DIV + 2);
    check("frz_sel_pre", int'(sel8), 3);
    scan_en = 1'b0;
    run(10);
    check("frz_sel_hold", int'(sel8), 3);
    scan_en = 1'b1;
    step();
    check("frz_no_adv", int'(sel8), 3);
    step();
    check("frz_adv_sel", int'(sel8), 4);
    check("frz_adv_tick", int'(tick8), 1);

    // Asynchronous reset between edges at sel 6, count 2
    do_reset();
    write_digit(0, 5);
    run(6 * DIV + 1);
    check("pre_arst_sel", int'(sel8), 6);
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_sel", int'(sel8), 0);
    check("arst_num", int'(num8), 0);
    check("arst_tick", int'(tick8), 0);
    check("arst_sel4", int'(sel4), 0);
    #2;
    rst = 1'b0;
    run(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      scan_en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 999) == 0) begin
        wr_en = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end
    wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
